// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory
// arbiter.
//   state_t      - controller state (IDLE / WIPE)
//   pipe_entry_t - read-tracking pipeline entry {valid, owner}
//   ADDR_W_DEF / DATA_W_DEF - default address and data widths
//   WIPE_LAST    - last address written by the wipe sequence
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] WIPE_LAST = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    WIPE = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } pipe_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   req    - per-requester request (already qualified by the caller)
//   accept - high when the current grant is taken this cycle
//   grant  - one-hot or zero grant, combinational from req and the pointer
// The pointer remembers the requester granted last; after reset it points
// at requester 1 so requester 0 wins the first contended round.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_reg;
  logic last_next;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: the requester that did not win last time goes first.
      2'b11:   grant = last_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // The pointer only moves when a grant is actually taken.
  always_comb begin
    last_next = last_reg;
    if (accept) begin
      last_next = grant[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester controller for the dual-bank memory interface.
//   clk, reset             - clock (rising edge), async active-low reset
//   wipe_req / busy        - wipe request (level) / high while wiping
//   req_valid / req_ready  - per-requester handshake (bit n = requester n)
//   req_rw                 - per-requester command type, 1 = write
//   req_addr_a/b           - packed per-requester addresses
//   req_wdata_a/b          - packed per-requester write data
//   rsp_valid              - one-cycle read-response strobe, one-hot or zero
//   rsp_a / rsp_b          - read data, straight from the memory outputs
//   mem_rw, mem_addr_a/b, mem_a/b - registered memory command
//   mem_a_out / mem_b_out  - registered memory read data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wipe_req,
  output logic                busy,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_rw,
  input  logic [2*ADDR_W-1:0] req_addr_a,
  input  logic [2*ADDR_W-1:0] req_addr_b,
  input  logic [2*DATA_W-1:0] req_wdata_a,
  input  logic [2*DATA_W-1:0] req_wdata_b,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_a,
  output logic [DATA_W-1:0]   rsp_b,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr_a,
  output logic [ADDR_W-1:0]   mem_addr_b,
  output logic [DATA_W-1:0]   mem_a,
  output logic [DATA_W-1:0]   mem_b,
  input  logic [DATA_W-1:0]   mem_a_out,
  input  logic [DATA_W-1:0]   mem_b_out
);

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  wipe_cnt_reg, wipe_cnt_next;
  logic               mem_rw_reg, mem_rw_next;
  logic [ADDR_W-1:0]  mem_addr_a_reg, mem_addr_a_next;
  logic [ADDR_W-1:0]  mem_addr_b_reg, mem_addr_b_next;
  logic [DATA_W-1:0]  mem_a_reg, mem_a_next;
  logic [DATA_W-1:0]  mem_b_reg, mem_b_next;
  pipe_entry_t        pipe0_reg, pipe0_next;
  pipe_entry_t        pipe1_reg;

  logic [ADDR_W-1:0]  addr_a_sl [2];
  logic [ADDR_W-1:0]  addr_b_sl [2];
  logic [DATA_W-1:0]  wdata_a_sl [2];
  logic [DATA_W-1:0]  wdata_b_sl [2];

  logic [1:0]         arb_req;
  logic [1:0]         grant;
  logic               accept;
  logic               gidx;

  // Unpack the per-requester command fields.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slice
    assign addr_a_sl[gi]  = req_addr_a[gi*ADDR_W +: ADDR_W];
    assign addr_b_sl[gi]  = req_addr_b[gi*ADDR_W +: ADDR_W];
    assign wdata_a_sl[gi] = req_wdata_a[gi*DATA_W +: DATA_W];
    assign wdata_b_sl[gi] = req_wdata_b[gi*DATA_W +: DATA_W];
  end

  // Requests are only offered to the arbiter in IDLE, and not in the cycle
  // that starts a wipe, so a pending wipe always takes precedence.
  assign arb_req = (state_reg == IDLE && !wipe_req) ? req_valid : 2'b00;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .accept (accept),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |(grant & req_valid);
  assign gidx      = grant[1];

  always_comb begin
    state_next      = state_reg;
    wipe_cnt_next   = wipe_cnt_reg;
    mem_rw_next     = 1'b0;            // idle cycles issue a harmless read
    mem_addr_a_next = mem_addr_a_reg;
    mem_addr_b_next = mem_addr_b_reg;
    mem_a_next      = mem_a_reg;
    mem_b_next      = mem_b_reg;
    pipe0_next      = '0;
    case (state_reg)
      IDLE: begin
        if (wipe_req) begin
          state_next    = WIPE;
          wipe_cnt_next = '0;
        end else if (accept) begin
          mem_rw_next = req_rw[gidx];
          if (req_rw[gidx]) begin
            // Both banks are written at the a-address of the command.
            mem_addr_a_next = addr_a_sl[gidx];
            mem_addr_b_next = addr_a_sl[gidx];
            mem_a_next      = wdata_a_sl[gidx];
            mem_b_next      = wdata_b_sl[gidx];
          end else begin
            mem_addr_a_next  = addr_a_sl[gidx];
            mem_addr_b_next  = addr_b_sl[gidx];
            pipe0_next.valid = 1'b1;
            pipe0_next.owner = gidx;
          end
        end
      end
      WIPE: begin
        mem_rw_next     = 1'b1;
        mem_addr_a_next = wipe_cnt_reg;
        mem_addr_b_next = wipe_cnt_reg;
        mem_a_next      = '0;
        mem_b_next      = '0;
        wipe_cnt_next   = wipe_cnt_reg + 1'b1;
        if (wipe_cnt_reg == ADDR_W'(WIPE_LAST)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // pipe0 is loaded on the accept edge, pipe1 on the edge the memory
  // samples the address, so pipe1 lines up with the memory's read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      wipe_cnt_reg   <= '0;
      mem_rw_reg     <= 1'b0;
      mem_addr_a_reg <= '0;
      mem_addr_b_reg <= '0;
      mem_a_reg      <= '0;
      mem_b_reg      <= '0;
      pipe0_reg      <= '0;
      pipe1_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      wipe_cnt_reg   <= wipe_cnt_next;
      mem_rw_reg     <= mem_rw_next;
      mem_addr_a_reg <= mem_addr_a_next;
      mem_addr_b_reg <= mem_addr_b_next;
      mem_a_reg      <= mem_a_next;
      mem_b_reg      <= mem_b_next;
      pipe0_reg      <= pipe0_next;
      pipe1_reg      <= pipe0_reg;
    end
  end

  assign busy       = (state_reg == WIPE);
  assign mem_rw     = mem_rw_reg;
  assign mem_addr_a = mem_addr_a_reg;
  assign mem_addr_b = mem_addr_b_reg;
  assign mem_a      = mem_a_reg;
  assign mem_b      = mem_b_reg;

  assign rsp_valid = pipe1_reg.valid ? (pipe1_reg.owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_a     = mem_a_out;
  assign rsp_b     = mem_b_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural
// dual-bank 16x8 memory (registered read, write on mem_rw).
module tb_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk;
  logic            reset;
  logic            wipe_req;
  logic            busy;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_rw;
  logic [2*AW-1:0] req_addr_a;
  logic [2*AW-1:0] req_addr_b;
  logic [2*DW-1:0] req_wdata_a;
  logic [2*DW-1:0] req_wdata_b;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_a;
  logic [DW-1:0]   rsp_b;
  logic            mem_rw;
  logic [AW-1:0]   mem_addr_a;
  logic [AW-1:0]   mem_addr_b;
  logic [DW-1:0]   mem_a;
  logic [DW-1:0]   mem_b;
  logic [DW-1:0]   mem_a_out;
  logic [DW-1:0]   mem_b_out;

  logic [DW-1:0]   bank_a [16];
  logic [DW-1:0]   bank_b [16];

  int n_cmp;
  int n_mis;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .wipe_req    (wipe_req),
    .busy        (busy),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw      (req_rw),
    .req_addr_a  (req_addr_a),
    .req_addr_b  (req_addr_b),
    .req_wdata_a (req_wdata_a),
    .req_wdata_b (req_wdata_b),
    .rsp_valid   (rsp_valid),
    .rsp_a       (rsp_a),
    .rsp_b       (rsp_b),
    .mem_rw      (mem_rw),
    .mem_addr_a  (mem_addr_a),
    .mem_addr_b  (mem_addr_b),
    .mem_a       (mem_a),
    .mem_b       (mem_b),
    .mem_a_out   (mem_a_out),
    .mem_b_out   (mem_b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: samples the command on the rising edge, registered read.
  initial begin
    for (int i = 0; i < 16; i++) begin
      bank_a[i] = '0;
      bank_b[i] = '0;
    end
    mem_a_out = '0;
    mem_b_out = '0;
  end

  always @(posedge clk) begin
    if (mem_rw) begin
      bank_a[mem_addr_a] <= mem_a;
      bank_b[mem_addr_b] <= mem_b;
    end
    mem_a_out <= bank_a[mem_addr_a];
    mem_b_out <= bank_b[mem_addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic rw, input logic [AW-1:0] aa,
                         input logic [AW-1:0] ab, input logic [DW-1:0] wa,
                         input logic [DW-1:0] wb);
    req_rw[r]               = rw;
    req_addr_a[r*AW +: AW]  = aa;
    req_addr_b[r*AW +: AW]  = ab;
    req_wdata_a[r*DW +: DW] = wa;
    req_wdata_b[r*DW +: DW] = wb;
  endtask

  initial begin
    int cnt;
    int j;
    logic [1:0] exp_rv;

    n_cmp       = 0;
    n_mis       = 0;
    reset       = 1'b0;
    wipe_req    = 1'b0;
    req_valid   = 2'b00;
    req_rw      = 2'b00;
    req_addr_a  = '0;
    req_addr_b  = '0;
    req_wdata_a = '0;
    req_wdata_b = '0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_rw", mem_rw, 0);
    check("rst_mem_addr_a", mem_addr_a, 0);
    check("rst_mem_addr_b", mem_addr_b, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_b", mem_b, 0);
    $display("reset state checked");
    reset = 1'b1;
    tick();

    // ---- requester 0 wins first contention after reset ----
    set_cmd(0, 1'b1, 4'd5, 4'd9, 8'h3C, 8'hA5);
    set_cmd(1, 1'b0, 4'd0, 4'd0, 8'h00, 8'h00);
    req_valid = 2'b11;
    #1;
    check("first_prio_ready", req_ready, 2'b01);

    // ---- write A=3C B=A5 at addr 5 (b address ignored for writes) ----
    req_valid = 2'b01;
    #1;
    check("wr_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("wr_mem_rw", mem_rw, 1);
    check("wr_mem_addr_a", mem_addr_a, 5);
    check("wr_mem_addr_b", mem_addr_b, 5);
    check("wr_mem_a", mem_a, 8'h3C);
    check("wr_mem_b", mem_b, 8'hA5);
    tick();
    check("idle_mem_rw", mem_rw, 0);
    check("idle_addr_hold", mem_addr_a, 5);
    check("wr_no_rsp", rsp_valid, 0);
    $display("write req0 addr 5 A=3c B=a5");

    // ---- single read by requester 0 ----
    set_cmd(0, 1'b0, 4'd5, 4'd5, 8'h00, 8'h00);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    check("rd_mem_rw", mem_rw, 0);
    check("rd_mem_addr_b", mem_addr_b, 5);
    check("rd_rsp_early", rsp_valid, 0);
    tick();
    check("rd_rsp_valid", rsp_valid, 2'b01);
    check("rd_rsp_a", rsp_a, 8'h3C);
    check("rd_rsp_b", rsp_b, 8'hA5);
    tick();
    check("rd_rsp_pulse_end", rsp_valid, 0);
    $display("read req0 addr 5 -> a=%0h b=%0h", 8'h3C, 8'hA5);

    // ---- requester 1 writes A=11 B=22 at addr 6 ----
    set_cmd(1, 1'b1, 4'd6, 4'd0, 8'h11, 8'h22);
    req_valid = 2'b10;
    #1;
    check("wr1_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("wr1_mem_addr_b", mem_addr_b, 6);
    tick();
    $display("write req1 addr 6 A=11 B=22");

    // ---- contention: both read for 4 cycles ----
    set_cmd(0, 1'b0, 4'd5, 4'd5, 8'h00, 8'h00);
    set_cmd(1, 1'b0, 4'd6, 4'd6, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        req_valid = 2'b11;
        #1;
        check("cont_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      end else begin
        req_valid = 2'b00;
      end
      tick();
      j = i - 1;
      exp_rv = (j >= 0 && j < 4) ? ((j % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check("cont_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv == 2'b01) begin
        check("cont_rsp_a0", rsp_a, 8'h3C);
        check("cont_rsp_b0", rsp_b, 8'hA5);
      end else if (exp_rv == 2'b10) begin
        check("cont_rsp_a1", rsp_a, 8'h11);
        check("cont_rsp_b1", rsp_b, 8'h22);
      end
      $display("contention cycle %0d ready=%b rsp_valid=%b", i, req_ready, rsp_valid);
    end

    // ---- fill all addresses with FF ----
    req_valid = 2'b01;
    for (int a = 0; a < 16; a++) begin
      set_cmd(0, 1'b1, 4'(a), 4'd0, 8'hFF, 8'hFF);
      tick();
    end
    req_valid = 2'b00;
    tick();
    $display("filled 16 addresses with ff");

    // ---- wipe with requester 1 held valid across it ----
    set_cmd(1, 1'b0, 4'd3, 4'd3, 8'h00, 8'h00);
    req_valid = 2'b10;
    wipe_req  = 1'b1;
    #1;
    check("wipe_req_ready", req_ready, 0);
    tick();
    wipe_req = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      check("wipe_ready_low", req_ready, 0);
      tick();
      cnt++;
    end
    check("wipe_busy_cycles", cnt, 16);
    check("post_wipe_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    check("post_wipe_rsp_valid", rsp_valid, 2'b10);
    check("post_wipe_rsp_a", rsp_a, 0);
    check("post_wipe_rsp_b", rsp_b, 0);
    $display("wipe busy for %0d cycles", cnt);

    // ---- read back all addresses, expect zero ----
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        set_cmd(0, 1'b0, 4'(i), 4'(i), 8'h00, 8'h00);
        req_valid = 2'b01;
      end else begin
        req_valid = 2'b00;
      end
      tick();
      if (i >= 1) begin
        check("wipe_rd_valid", rsp_valid, 2'b01);
        check("wipe_rd_a", rsp_a, 0);
        check("wipe_rd_b", rsp_b, 0);
        $display("readback addr %0d a=%0h b=%0h", i - 1, rsp_a, rsp_b);
      end
    end
    tick();

    // ---- read/wipe overlap ----
    set_cmd(0, 1'b1, 4'd7, 4'd2, 8'h5A, 8'hC3);
    req_valid = 2'b01;
    tick();
    set_cmd(0, 1'b0, 4'd7, 4'd7, 8'h00, 8'h00);
    tick();
    req_valid = 2'b00;
    wipe_req  = 1'b1;
    tick();
    wipe_req = 1'b0;
    check("ovl_rsp_valid", rsp_valid, 2'b01);
    check("ovl_rsp_a", rsp_a, 8'h5A);
    check("ovl_rsp_b", rsp_b, 8'hC3);
    check("ovl_busy", busy, 1);
    cnt = 0;
    while (busy && cnt < 40) begin
      tick();
      cnt++;
    end
    check("ovl_busy_cycles", cnt, 16);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    check("ovl_after_a", rsp_a, 0);
    check("ovl_after_b", rsp_b, 0);
    $display("overlap read delivered, wipe %0d cycles", cnt);

    // ---- reset mid-read ----
    set_cmd(0, 1'b0, 4'd5, 4'd5, 8'h00, 8'h00);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    reset     = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_mem_rw", mem_rw, 0);
    check("mid_rst_addr_a", mem_addr_a, 0);
    check("mid_rst_addr_b", mem_addr_b, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("in_rst_rsp_valid", rsp_valid, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rsp_valid", rsp_valid, 0);
    end
    req_valid = 2'b11;
    #1;
    check("post_rst_prio", req_ready, 2'b01);
    req_valid = 2'b00;
    $display("reset mid-read: no response after release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
